// File: rtl/mc_control_if.sv
// Control bundle between the multicycle controller and its datapath.
// The master modport is the controller; the slave is the datapath side.
interface mc_control_if;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic        iord;
  logic        ir_write;
  logic        mem_write;
  logic        reg_dst;
  logic        mem_to_reg;
  logic        reg_write;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  pc_src;
  logic [2:0]  alu_ctrl;
  logic        pc_en;
  logic        illegal;
  logic [31:0] instret;
  logic [3:0]  state;

  modport master (
    input  opcode, funct, zero,
    output iord, ir_write, mem_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
    output alu_src_b, pc_src, alu_ctrl, pc_en, illegal, instret, state
  );

  modport slave (
    output opcode, funct, zero,
    input  iord, ir_write, mem_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
    input  alu_src_b, pc_src, alu_ctrl, pc_en, illegal, instret, state
  );
endinterface

// File: rtl/mc_control.sv
// Multicycle MIPS-style main controller: Moore FSM plus retired-instruction counter.
// Define MC_JUMP_EN to support the j instruction; otherwise opcode 000010 is illegal.
module mc_control (
  input  logic         clk,
  input  logic         reset,
  mc_control_if.master bus
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StAluWb  = 4'd7,
    StBeq    = 4'd8,
    StAddiEx = 4'd9,
    StAddiWb = 4'd10,
    StJump   = 4'd11
  } state_e;

  localparam logic [5:0] OpLw   = 6'b100011;
  localparam logic [5:0] OpSw   = 6'b101011;
  localparam logic [5:0] OpRtyp = 6'b000000;
  localparam logic [5:0] OpBeq  = 6'b000100;
  localparam logic [5:0] OpAddi = 6'b001000;
`ifdef MC_JUMP_EN
  localparam logic [5:0] OpJ    = 6'b000010;
`endif

  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluSlt = 3'b111;

  state_e      state_q;
  logic [31:0] instret_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StFetch;
      instret_q <= 32'd0;
    end else begin
      case (state_q)
        StFetch:  state_q <= StDecode;
        StDecode: begin
          case (bus.opcode)
            OpLw, OpSw: state_q <= StMemAdr;
            OpRtyp:     state_q <= StExec;
            OpBeq:      state_q <= StBeq;
            OpAddi:     state_q <= StAddiEx;
`ifdef MC_JUMP_EN
            OpJ:        state_q <= StJump;
`endif
            default:    state_q <= StFetch;
          endcase
        end
        StMemAdr: state_q <= (bus.opcode == OpLw) ? StMemRd : StMemWr;
        StMemRd:  state_q <= StMemWb;
        StExec:   state_q <= StAluWb;
        StAddiEx: state_q <= StAddiWb;
`ifdef MC_JUMP_EN
        StJump,
`endif
        StMemWb, StMemWr, StAluWb, StBeq, StAddiWb: begin
          state_q   <= StFetch;
          instret_q <= instret_q + 32'd1;
        end
        default:  state_q <= StFetch;
      endcase
    end
  end

  logic       legal_op;
  logic [2:0] alu_fn;

  always_comb begin
    case (bus.opcode)
      OpLw, OpSw, OpRtyp, OpBeq, OpAddi: legal_op = 1'b1;
`ifdef MC_JUMP_EN
      OpJ:                               legal_op = 1'b1;
`endif
      default:                           legal_op = 1'b0;
    endcase
  end

  always_comb begin
    case (bus.funct)
      6'b100010: alu_fn = AluSub;
      6'b100100: alu_fn = AluAnd;
      6'b100101: alu_fn = AluOr;
      6'b101010: alu_fn = AluSlt;
      default:   alu_fn = AluAdd;
    endcase
  end

  logic       iord, ir_write, mem_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_ctrl;
  logic       pc_write, branch, illegal;

  always_comb begin
    iord       = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_src     = 2'b00;
    alu_ctrl   = 3'b000;
    pc_write   = 1'b0;
    branch     = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      StFetch: begin
        ir_write  = 1'b1;
        alu_src_b = 2'b01;
        alu_ctrl  = AluAdd;
        pc_write  = 1'b1;
      end
      StDecode: begin
        alu_src_b = 2'b11;
        alu_ctrl  = AluAdd;
        illegal   = ~legal_op;
      end
      StMemAdr, StAddiEx: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_ctrl  = AluAdd;
      end
      StMemRd:  iord = 1'b1;
      StMemWr: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      StMemWb: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      StAddiWb: reg_write = 1'b1;
      StAluWb: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      StExec: begin
        alu_src_a = 1'b1;
        alu_ctrl  = alu_fn;
      end
      StBeq: begin
        alu_src_a = 1'b1;
        alu_ctrl  = AluSub;
        pc_src    = 2'b01;
        branch    = 1'b1;
      end
`ifdef MC_JUMP_EN
      StJump: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
`endif
      default: ;
    endcase
    // Reset holds the FETCH decode but suppresses every side effect.
    if (reset) begin
      ir_write  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      illegal   = 1'b0;
      pc_write  = 1'b0;
      branch    = 1'b0;
    end
  end

  assign bus.iord       = iord;
  assign bus.ir_write   = ir_write;
  assign bus.mem_write  = mem_write;
  assign bus.reg_dst    = reg_dst;
  assign bus.mem_to_reg = mem_to_reg;
  assign bus.reg_write  = reg_write;
  assign bus.alu_src_a  = alu_src_a;
  assign bus.alu_src_b  = alu_src_b;
  assign bus.pc_src     = pc_src;
  assign bus.alu_ctrl   = alu_ctrl;
  assign bus.pc_en      = pc_write | (branch & bus.zero);
  assign bus.illegal    = illegal;
  assign bus.instret    = instret_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares state, controls and instret.
module tb_mc_control;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mc_control_if bus ();

  mc_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [3:0]  st;
    logic [15:0] ctl;
    logic [31:0] ir;
  } exp_t;

  exp_t        exp_q[$];
  string       name_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] model_ir = 32'd0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, got, want);
    end
  endtask

  // Expected controls per state, packed as
  // {iord,ir_write,mem_write,reg_dst,mem_to_reg,reg_write,alu_src_a,
  //  alu_src_b[1:0],pc_src[1:0],alu_ctrl[2:0],pc_en,illegal}
  function automatic logic [15:0] exp_ctrl(input logic [3:0] st, input logic [5:0] fn,
                                           input logic z, input logic ill, input logic rst);
    logic       iord, irw, mw, rd, m2r, rw, asa, pce, il;
    logic [1:0] asb, ps;
    logic [2:0] ac;
    {iord, irw, mw, rd, m2r, rw, asa, pce, il} = '0;
    asb = 2'b00;
    ps  = 2'b00;
    ac  = 3'b000;
    case (st)
      4'd0:  begin irw = 1'b1; asb = 2'b01; ac = 3'b010; pce = 1'b1; end
      4'd1:  begin asb = 2'b11; ac = 3'b010; il = ill; end
      4'd2,
      4'd9:  begin asa = 1'b1; asb = 2'b10; ac = 3'b010; end
      4'd3:  iord = 1'b1;
      4'd4:  begin m2r = 1'b1; rw = 1'b1; end
      4'd5:  begin iord = 1'b1; mw = 1'b1; end
      4'd6: begin
        asa = 1'b1;
        case (fn)
          6'b100010: ac = 3'b110;
          6'b100100: ac = 3'b000;
          6'b100101: ac = 3'b001;
          6'b101010: ac = 3'b111;
          default:   ac = 3'b010;
        endcase
      end
      4'd7:  begin rd = 1'b1; rw = 1'b1; end
      4'd8:  begin asa = 1'b1; ac = 3'b110; ps = 2'b01; pce = z; end
      4'd10: rw = 1'b1;
      4'd11: begin ps = 2'b10; pce = 1'b1; end
      default: ;
    endcase
    if (rst) begin
      irw = 1'b0; mw = 1'b0; rw = 1'b0; il = 1'b0; pce = 1'b0;
    end
    return {iord, irw, mw, rd, m2r, rw, asa, asb, ps, ac, pce, il};
  endfunction

  task automatic push(input string nm, input logic [3:0] st, input logic [15:0] c,
                      input logic [31:0] ir);
    exp_t e;
    e.st  = st;
    e.ctl = c;
    e.ir  = ir;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // seqv holds one state per nibble, first cycle in the low nibble.
  task automatic run(input string nm, input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input logic ill, input logic [23:0] seqv,
                     input int n, input bit retire);
    logic [3:0] st;
    bus.opcode = op;
    bus.funct  = fn;
    bus.zero   = z;
    for (int i = 0; i < n; i++) begin
      st = seqv[i*4 +: 4];
      push($sformatf("%s[%0d]", nm, i), st, exp_ctrl(st, fn, z, ill, 1'b0), model_ir);
      @(posedge clk);
      #1;
    end
    if (retire) model_ir = model_ir + 32'd1;
  endtask

  // Monitor
  initial begin
    exp_t        e;
    string       nm;
    logic [15:0] got;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        got = {bus.iord, bus.ir_write, bus.mem_write, bus.reg_dst, bus.mem_to_reg,
               bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.pc_src, bus.alu_ctrl,
               bus.pc_en, bus.illegal};
        check({nm, "/state"}, {28'd0, bus.state}, {28'd0, e.st});
        check({nm, "/ctl"}, {16'd0, got}, {16'd0, e.ctl});
        check({nm, "/instret"}, bus.instret, e.ir);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    bus.opcode = 6'd0;
    bus.funct  = 6'd0;
    bus.zero   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      push("reset", 4'd0, exp_ctrl(4'd0, 6'd0, 1'b0, 1'b0, 1'b1), 32'd0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;

    run("lw",     6'b100011, 6'd0,      1'b0, 1'b0, 24'h043210, 5, 1'b1);
    run("sw",     6'b101011, 6'd0,      1'b0, 1'b0, 24'h005210, 4, 1'b1);
    run("slt",    6'b000000, 6'b101010, 1'b0, 1'b0, 24'h007610, 4, 1'b1);
    run("sub",    6'b000000, 6'b100010, 1'b0, 1'b0, 24'h007610, 4, 1'b1);
    run("and",    6'b000000, 6'b100100, 1'b0, 1'b0, 24'h007610, 4, 1'b1);
    run("or",     6'b000000, 6'b100101, 1'b0, 1'b0, 24'h007610, 4, 1'b1);
    run("rdflt",  6'b000000, 6'b000111, 1'b0, 1'b0, 24'h007610, 4, 1'b1);
    run("addi",   6'b001000, 6'd0,      1'b0, 1'b0, 24'h00A910, 4, 1'b1);
    run("beq_t",  6'b000100, 6'd0,      1'b1, 1'b0, 24'h000810, 3, 1'b1);
    run("beq_nt", 6'b000100, 6'd0,      1'b0, 1'b0, 24'h000810, 3, 1'b1);
    run("ill",    6'b111111, 6'd0,      1'b0, 1'b1, 24'h000010, 2, 1'b0);
`ifdef MC_JUMP_EN
    run("j",      6'b000010, 6'd0,      1'b0, 1'b0, 24'h000B10, 3, 1'b1);
`else
    run("j_ill",  6'b000010, 6'd0,      1'b0, 1'b1, 24'h000010, 2, 1'b0);
`endif

    // Reset while in MEMRD: must clear asynchronously and never reach MEMWB.
    run("lw_abort", 6'b100011, 6'd0, 1'b0, 1'b0, 24'h000210, 3, 1'b0);
    push("lw_abort[3]", 4'd3, exp_ctrl(4'd3, 6'd0, 1'b0, 1'b0, 1'b0), model_ir);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("async_rst/state", {28'd0, bus.state}, 32'd0);
    check("async_rst/instret", bus.instret, 32'd0);
    model_ir = 32'd0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      push("rst_hold", 4'd0, exp_ctrl(4'd0, 6'd0, 1'b0, 1'b0, 1'b1), 32'd0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    run("lw_after", 6'b100011, 6'd0, 1'b0, 1'b0, 24'h043210, 5, 1'b1);

    // instret wrap: preload all-ones during ADDIWB, then retire.
    run("addi_wrap", 6'b001000, 6'd0, 1'b0, 1'b0, 24'h000910, 3, 1'b0);
    push("addi_wrap[3]", 4'd10, exp_ctrl(4'd10, 6'd0, 1'b0, 1'b0, 1'b0), model_ir);
    @(negedge clk);
    #1;
    force dut.instret_q = 32'hFFFF_FFFF;
    #1;
    release dut.instret_q;
    @(posedge clk);
    #1;
    model_ir = 32'd0;
    run("post_wrap", 6'b001000, 6'd0, 1'b0, 1'b0, 24'h000010, 1, 1'b0);

    repeat (2) @(negedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 Parameters: none; all encodings fixed by this document.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 opcode  input  6  instr[31:26] from instruction register.
REQ-005 funct  input  6  instr[5:0] from instruction register.
REQ-006 zero  input  1  ALU zero flag.
REQ-007 iord, ir_write, mem_write, reg_dst, mem_to_reg, reg_write, alu_src_a  output  1 each  datapath mux/enable controls.
REQ-008 alu_src_b  output  2  00=rd2, 01=const 4, 10=sign_imm, 11=sign_imm<<2.
REQ-009 pc_src  output  2  00=ALU result, 01=ALU out reg, 10=jump target.
REQ-010 alu_ctrl  output  3  ALU operation code: 010 add, 110 sub, 000 and, 001 or, 111 slt.
REQ-011 pc_en  output  1  PC register load enable.
REQ-012 illegal  output  1  one-cycle pulse on unsupported opcode.
REQ-013 instret  output  32  count of retired instructions.
REQ-014 state  output  4  current FSM state, for debug.

Function
REQ-015 FSM states SHALL be encoded FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BEQ=8, ADDIEX=9, ADDIWB=10, JUMP=11; codes 12-15 go to FETCH on the next edge.
REQ-016 Transitions: FETCH->DECODE; DECODE by opcode: 100011/101011->MEMADR, 000000->EXEC, 000100->BEQ, 001000->ADDIEX, 000010->JUMP (see REQ-030), other->FETCH.
REQ-017 MEMADR->MEMRD (lw) or MEMWR (sw); MEMRD->MEMWB; EXEC->ALUWB; ADDIEX->ADDIWB; MEMWB, MEMWR, ALUWB, BEQ, ADDIWB, JUMP->FETCH.
REQ-018 Outputs are Moore, decoded from state; every control not listed for a state is 0.
REQ-019 FETCH: ir_write=1, alu_src_b=01, alu_ctrl=010, pc_write=1.
REQ-020 DECODE: alu_src_b=11, alu_ctrl=010. MEMADR and ADDIEX: alu_src_a=1, alu_src_b=10, alu_ctrl=010.
REQ-021 MEMRD: iord=1. MEMWR: iord=1, mem_write=1. MEMWB: mem_to_reg=1, reg_write=1. ADDIWB: reg_write=1. ALUWB: reg_dst=1, reg_write=1.
REQ-022 EXEC: alu_src_a=1; alu_ctrl by funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111, other->010.
REQ-023 BEQ: alu_src_a=1, alu_ctrl=110, pc_src=01, branch=1. JUMP: pc_src=10, pc_write=1.
REQ-024 pc_en = pc_write | (branch & zero), combinational; zero is sampled only in BEQ.
REQ-025 Instruction latency from entering FETCH: lw 5 cycles, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
REQ-026 illegal = 1 for exactly the DECODE cycle with an unsupported opcode; no register or memory write occurs for that instruction.
REQ-027 instret increments by 1 on each transition into FETCH from MEMWB, MEMWR, ALUWB, BEQ, ADDIWB or JUMP; no increment on the illegal path. It wraps 0xFFFFFFFF->0.

Reset
REQ-028 While reset=1: state=FETCH, instret=0, and pc_en, ir_write, mem_write, reg_write and illegal are forced to 0. Other outputs take their FETCH values.
REQ-029 Reset asserted mid-instruction abandons the instruction with no further writes. The first rising edge after deassertion performs FETCH.

Configuration
REQ-030 Macro MC_JUMP_EN:
- defined: opcode 000010 routes DECODE->JUMP.
- undefined: JUMP state is absent; opcode 000010 is illegal per REQ-026.

Verification
REQ-031 lw (100011) after reset: states 0,1,2,3,4,0. reg_write=1 and mem_to_reg=1 only in MEMWB. instret 0->1.
REQ-032 beq with zero=1: pc_en=1 in BEQ with pc_src=01. With zero=0: pc_en=0 in BEQ. instret increments in both cases.
REQ-033 R-type funct 101010: alu_ctrl=111 in EXEC, reg_dst=1 and reg_write=1 in ALUWB, 4 cycles total.
REQ-034 opcode 111111: illegal=1 for one cycle in DECODE, then FETCH. No reg_write or mem_write; instret unchanged. Repeat with 000010 and MC_JUMP_EN undefined.
REQ-035 Assert reset during MEMRD: state=0 and instret=0 immediately, asynchronously. No MEMWB is ever entered; next instruction fetches normally.
REQ-036 Preload instret=0xFFFFFFFF (force), retire one addi: instret=0x00000000.
